// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte sequencer.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_e;

  localparam logic [7:0] DEFAULT_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/spi_byte_sequencer_if.sv
// Byte-stream handshakes of the sequencer: TX push side and RX pop side.
interface spi_byte_sequencer_if;

  logic [7:0] s_tx_data;
  logic       s_tx_valid;
  logic       s_tx_ready;
  logic [7:0] m_rx_data;
  logic       m_rx_valid;
  logic       m_rx_ready;

  modport master (
    output s_tx_data, s_tx_valid, m_rx_ready,
    input  s_tx_ready, m_rx_data, m_rx_valid
  );

  modport slave (
    input  s_tx_data, s_tx_valid, m_rx_ready,
    output s_tx_ready, m_rx_data, m_rx_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// 8-bit synchronous first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_COUNT) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_COUNT);
  assign count    = count_q;
  assign pop_data = empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: rtl/spi_byte_sequencer.sv
// Sequences TX FIFO bytes into an SPI physical stage and collects replies.
// Define SPI_SEQ_RX_EN to build the RX FIFO and RX handshake.
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter int         LEN_W      = 16,
  parameter logic [7:0] FILL_BYTE  = DEFAULT_FILL_BYTE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     xfer_len,
  output logic                 busy,
  output logic                 done,
  spi_byte_sequencer_if.slave  bus,
  output logic                 tx_underrun,
  output logic                 rx_overflow,
  input  logic                 clear_flags,
  output logic                 phy_ena,
  output logic [7:0]           phy_data_in,
  input  logic                 phy_new_byte,
  input  logic                 phy_system_idle,
  input  logic [7:0]           phy_data_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  seq_state_e       state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             phy_ena_q, phy_ena_d;
  logic [7:0]       phy_data_q, phy_data_d;
  logic             from_fifo_q, from_fifo_d;
  logic             reload_q, reload_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_head, head_or_fill;
  logic [CW-1:0]    tx_count;
  logic             rx_capture, underrun_event;

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (bus.s_tx_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  assign bus.s_tx_ready = !tx_full;
  assign tx_push        = bus.s_tx_valid && !tx_full;
  assign head_or_fill   = tx_empty ? FILL_BYTE : tx_head;

  // The byte on phy_data_in is registered and only refreshed the cycle after a
  // phy_new_byte; from_fifo_q remembers whether it was a real TX byte, so the
  // pop or underrun decision matches what the phy actually shifted out.
  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    phy_ena_d      = phy_ena_q;
    phy_data_d     = phy_data_q;
    from_fifo_d    = from_fifo_q;
    reload_d       = 1'b0;
    done_d         = 1'b0;
    tx_pop         = 1'b0;
    rx_capture     = 1'b0;
    underrun_event = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        phy_ena_d   = 1'b0;
        phy_data_d  = 8'h00;
        from_fifo_d = 1'b0;
        if (start) begin
          if (xfer_len == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = xfer_len;
            state_d     = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        if (phy_system_idle) begin
          phy_ena_d   = 1'b1;
          phy_data_d  = head_or_fill;
          from_fifo_d = !tx_empty;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (reload_q) begin
          phy_data_d  = head_or_fill;
          from_fifo_d = !tx_empty;
        end
        if (phy_new_byte) begin
          rx_capture     = 1'b1;
          tx_pop         = from_fifo_q;
          underrun_event = !from_fifo_q;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - LEN_W'(1);
          end
          if (remaining_q <= LEN_W'(1)) begin
            phy_ena_d = 1'b0;
            state_d   = ST_FINISH;
          end else begin
            reload_d = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        if (phy_system_idle) begin
          done_d      = 1'b1;
          phy_data_d  = 8'h00;
          from_fifo_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    underrun_d = (underrun_q && !clear_flags) || underrun_event;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      phy_ena_q   <= 1'b0;
      phy_data_q  <= 8'h00;
      from_fifo_q <= 1'b0;
      reload_q    <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      phy_ena_q   <= phy_ena_d;
      phy_data_q  <= phy_data_d;
      from_fifo_q <= from_fifo_d;
      reload_q    <= reload_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign phy_ena     = phy_ena_q;
  assign phy_data_in = phy_data_q;
  assign tx_underrun = underrun_q;

`ifdef SPI_SEQ_RX_EN
  logic          rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_data;
  logic [CW-1:0] rx_count;
  logic          overflow_q, overflow_d;
  logic          unused_bits;

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_capture),
    .push_data (phy_data_out),
    .pop       (rx_pop),
    .pop_data  (rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  assign rx_pop         = !rx_empty && bus.m_rx_ready;
  assign bus.m_rx_valid = !rx_empty;
  assign bus.m_rx_data  = rx_data;

  always_comb begin
    overflow_d = (overflow_q && !clear_flags) || (rx_capture && rx_full && !rx_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign rx_overflow = overflow_q;
  assign unused_bits = ^{tx_count, rx_count};
`else
  logic unused_bits;

  assign bus.m_rx_valid = 1'b0;
  assign bus.m_rx_data  = 8'h00;
  assign rx_overflow    = 1'b0;
  assign unused_bits    = ^{tx_count, phy_data_out, bus.m_rx_ready, rx_capture};
`endif

endmodule
